// File: rtl/write_back_addr_gen.sv
// write_back_addr_gen: per-pixel feature-map write address generator
// with start/done handshake, valid/ready backpressure and error pulse.
module write_back_addr_gen #(
    parameter int ADDR_W      = 19,
    parameter int OPC_W       = 6,
    parameter int NUM_PORTS   = 3,
    parameter int MAP_WORDS   = 4096,
    parameter int SINGLE_OPS  = 16,
    parameter int SINGLE_BASE = 3,
    parameter int MULTI_OPS   = 16,
    parameter int MULTI_BASE  = 19,
    parameter int SPARE_IDX   = 67
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [OPC_W-1:0]            i_opcode,
    input  logic [12:0]                 i_pixCount,
    input  logic                        i_pixValid,
    output logic                        o_pixReady,
    output logic                        o_wrValid,
    input  logic                        i_memReady,
    output logic [NUM_PORTS-1:0]        o_wrEn,
    output logic [NUM_PORTS*ADDR_W-1:0] o_wrAddr,
    output logic                        o_wrLast,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err
);

    localparam int SHIFT = $clog2(MAP_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    if ((longint'(1) << SHIFT) != longint'(MAP_WORDS)) begin : g_pow2_chk
        $error("MAP_WORDS must be a power of two");
    end

    if (longint'(SPARE_IDX + 1) * longint'(MAP_WORDS)
        > (longint'(1) << ADDR_W)) begin : g_range_chk
        $error("feature-map slots exceed the address space");
    end

    logic [31:0]                 w_op;
    logic [31:0]                 w_multiIdx;
    logic                        w_single;
    logic                        w_multi;
    logic                        w_cntOk;
    logic [NUM_PORTS*ADDR_W-1:0] w_base;
    logic [NUM_PORTS-1:0]        w_mask;
    logic [NUM_PORTS*ADDR_W-1:0] w_nextAddr;
    logic                        w_run;
    logic                        w_pixReady;
    logic                        w_accept;
    logic                        w_retire;
    logic                        w_lastPix;

    logic [1:0]                  r_state;
    logic [NUM_PORTS*ADDR_W-1:0] r_base;
    logic [NUM_PORTS-1:0]        r_mask;
    logic [12:0]                 r_count;
    logic [12:0]                 r_pix;
    logic                        r_wrValid;
    logic [NUM_PORTS-1:0]        r_wrEn;
    logic [NUM_PORTS*ADDR_W-1:0] r_wrAddr;
    logic                        r_wrLast;
    logic                        r_done;
    logic                        r_err;

    assign w_op       = 32'(i_opcode);
    assign w_single   = w_op < 32'(SINGLE_OPS);
    assign w_multi    = !w_single && (w_op < 32'(SINGLE_OPS + MULTI_OPS));
    assign w_multiIdx = 32'(MULTI_BASE)
                      + 32'(NUM_PORTS) * (w_op - 32'(SINGLE_OPS));
    assign w_cntOk    = (i_pixCount != 13'd0)
                     && ({19'd0, i_pixCount} <= 32'(MAP_WORDS));

    // Slot index scaled by a power-of-two map size is a plain shift.
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        logic [31:0] w_idx;
        if (k == 0) begin : g_p0
            assign w_idx = w_single ? 32'(SINGLE_BASE) + w_op : w_multiIdx;
        end else begin : g_pk
            assign w_idx = w_single ? 32'(SPARE_IDX) : w_multiIdx + 32'(k);
        end
        assign w_base[k*ADDR_W +: ADDR_W] = ADDR_W'(w_idx << SHIFT);
        assign w_mask[k] = (k == 0) || w_multi;
        assign w_nextAddr[k*ADDR_W +: ADDR_W] =
            r_base[k*ADDR_W +: ADDR_W] + ADDR_W'(r_pix);
    end

    assign w_run      = r_state == S_RUN;
    assign w_pixReady = w_run && (!r_wrValid || i_memReady);
    assign w_accept   = w_pixReady && i_pixValid;
    assign w_retire   = r_wrValid && i_memReady;
    assign w_lastPix  = r_pix == (r_count - 13'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_mask    <= '0;
            r_count   <= '0;
            r_pix     <= '0;
            r_wrValid <= 1'b0;
            r_wrEn    <= '0;
            r_wrAddr  <= '0;
            r_wrLast  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_accept) begin
                r_wrAddr  <= w_nextAddr;
                r_wrEn    <= r_mask;
                r_wrValid <= 1'b1;
                r_wrLast  <= w_lastPix;
            end else if (w_retire) begin
                r_wrValid <= 1'b0;
                r_wrEn    <= '0;
                r_wrLast  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if ((w_single || w_multi) && w_cntOk) begin
                            r_base  <= w_base;
                            r_mask  <= w_mask;
                            r_count <= i_pixCount;
                            r_pix   <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_pix <= r_pix + 13'd1;
                        if (w_lastPix) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_retire) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_pixReady = w_pixReady;
    assign o_wrValid  = r_wrValid;
    assign o_wrEn     = r_wrEn;
    assign o_wrAddr   = r_wrAddr;
    assign o_wrLast   = r_wrLast;
    assign o_busy     = r_state != S_IDLE;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule
